// File: rtl/ysyx_22050039_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_lsu_pkg
//  Purpose  : Shared definitions for the load/store unit: op field positions,
//             access size codes, response error codes and FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package ysyx_22050039_lsu_pkg;

  // Bit positions inside req_op
  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  // Access size codes, req_op[1:0] = log2(bytes)
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Response error codes
  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Address bits that must be zero for a naturally aligned access of this size
  function automatic logic [2:0] size_lowmask(input logic [1:0] size);
    case (size)
      SIZE_B:  size_lowmask = 3'b000;
      SIZE_H:  size_lowmask = 3'b001;
      SIZE_W:  size_lowmask = 3'b011;
      default: size_lowmask = 3'b111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22050039_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_lsu_align
//  Purpose  : Combinational byte-lane steering for the LSU. Builds the byte
//             enable mask, shifts store data onto its lanes and extracts /
//             extends load data from a full-word memory read.
//  Ports    : i_off       byte offset inside the memory word
//             i_size      log2 access bytes
//             i_unsigned  zero-extend loads when set
//             i_wdata     store data, LSB-justified
//             i_rdata     full-word read data
//             o_wmask     byte enables
//             o_wdata_sh  store data on its byte lanes
//             o_rdata_ext aligned and extended load data
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050039_lsu_align
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter  int XLEN  = 64,
  localparam int MW    = XLEN / 8,
  localparam int OFF_W = $clog2(MW)
) (
  input  logic [OFF_W-1:0] i_off,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [MW-1:0]    o_wmask,
  output logic [XLEN-1:0]  o_wdata_sh,
  output logic [XLEN-1:0]  o_rdata_ext
);

  logic [MW-1:0]   w_mask_base;
  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_keep;
  logic            w_sign;

  always_comb begin
    w_mask_base = '0;
    w_keep      = '0;
    w_sign      = 1'b0;
    w_shift     = i_rdata >> {i_off, 3'b000};
    case (i_size)
      SIZE_B: begin
        w_mask_base = MW'(1);
        w_keep      = XLEN'(8'hFF);
        w_sign      = w_shift[7];
      end
      SIZE_H: begin
        w_mask_base = MW'(3);
        w_keep      = XLEN'(16'hFFFF);
        w_sign      = w_shift[15];
      end
      SIZE_W: begin
        w_mask_base = MW'(15);
        w_keep      = XLEN'(32'hFFFF_FFFF);
        w_sign      = w_shift[31];
      end
      default: begin
        // Full-width access: nothing above to extend into
        w_mask_base = '1;
        w_keep      = '1;
        w_sign      = 1'b0;
      end
    endcase
    o_wmask     = w_mask_base << i_off;
    o_wdata_sh  = i_wdata << {i_off, 3'b000};
    o_rdata_ext = (w_shift & w_keep) | (~w_keep & {XLEN{w_sign & ~i_unsigned}});
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_22050039_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_22050039_lsu
//  Purpose  : Multi-cycle load/store unit between EXU and data memory. Accepts
//             one op per handshake, forms addr = base + offset, issues a
//             valid/ready memory request with byte-lane mask, aligns/extends
//             load data and reports misaligned or timed-out accesses.
//             Only one op is in flight at a time.
//  Ports    : clk/rst          clock, asynchronous active-high reset
//             i_req_*/o_req_*  EXU request channel
//             o_resp_*/i_resp_ready  result channel (data, 2-bit error)
//             o_mem_*/i_mem_*  memory request / response channel
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_22050039_lsu
  import ysyx_22050039_lsu_pkg::*;
#(
  parameter  int XLEN    = 64,
  parameter  int TIMEOUT = 255,
  parameter  int CNT_W   = 8,
  localparam int MW      = XLEN / 8,
  localparam int OFF_W   = $clog2(MW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [3:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_base,
  input  logic [XLEN-1:0] i_req_offset,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_data,
  output logic [1:0]      o_resp_err,
  output logic            o_mem_req_valid,
  input  logic            i_mem_req_ready,
  output logic [XLEN-1:0] o_mem_addr,
  output logic            o_mem_wen,
  output logic [XLEN-1:0] o_mem_wdata,
  output logic [MW-1:0]   o_mem_wmask,
  input  logic            i_mem_rvalid,
  input  logic [XLEN-1:0] i_mem_rdata
);

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_op;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_resp_data;
  logic [1:0]        r_resp_err;

  logic [XLEN-1:0]   w_addr;
  logic              w_misaligned;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_timeout;
  logic [MW-1:0]     w_wmask;
  logic [XLEN-1:0]   w_wdata_sh;
  logic [XLEN-1:0]   w_rdata_ext;

  // Address add wraps naturally at XLEN bits
  assign w_addr       = i_req_base + i_req_offset;
  assign w_misaligned = ((w_addr[2:0] & size_lowmask(i_req_op[1:0])) != 3'b000) ||
                        ((XLEN == 32) && (i_req_op[1:0] == SIZE_D));

  // The cycle being spent now is counted, so the FSM leaves after exactly
  // TIMEOUT cycles in REQ+WAIT.
  assign w_cnt_next = r_cnt + CNT_W'(1);
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == CNT_W'(TIMEOUT));

  ysyx_22050039_lsu_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_off       (r_addr[OFF_W-1:0]),
    .i_size      (r_op[1:0]),
    .i_unsigned  (r_op[OP_UNSIGNED]),
    .i_wdata     (r_wdata),
    .i_rdata     (i_mem_rdata),
    .o_wmask     (w_wmask),
    .o_wdata_sh  (w_wdata_sh),
    .o_rdata_ext (w_rdata_ext)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_req_valid) w_state_next = w_misaligned ? S_RESP : S_REQ;
      // Timeout takes precedence over a same-cycle request handshake
      S_REQ: begin
        if (w_timeout)            w_state_next = S_RESP;
        else if (i_mem_req_ready) w_state_next = S_WAIT;
      end
      // A response arriving on the final allowed cycle still counts
      S_WAIT: if (i_mem_rvalid || w_timeout) w_state_next = S_RESP;
      S_RESP: if (i_resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs: memory port is driven only while a request is outstanding
  always_comb begin
    o_req_ready     = (r_state == S_IDLE);
    o_resp_valid    = (r_state == S_RESP);
    o_resp_data     = r_resp_data;
    o_resp_err      = r_resp_err;
    o_mem_req_valid = 1'b0;
    o_mem_wen       = 1'b0;
    o_mem_addr      = '0;
    o_mem_wdata     = '0;
    o_mem_wmask     = '0;
    if (r_state == S_REQ) begin
      o_mem_req_valid = 1'b1;
      o_mem_wen       = r_op[OP_STORE];
      o_mem_addr      = {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      o_mem_wdata     = w_wdata_sh;
      o_mem_wmask     = w_wmask;
    end
  end

  // Datapath: latched request, timeout counter, response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_resp_data <= '0;
      r_resp_err  <= ERR_OK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_op    <= i_req_op;
            r_addr  <= w_addr;
            r_wdata <= i_req_wdata;
            r_cnt   <= '0;
            if (w_misaligned) begin
              r_resp_data <= '0;
              r_resp_err  <= ERR_MISALIGN;
            end
          end
        end
        S_REQ: begin
          r_cnt <= w_cnt_next;
          if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_err  <= ERR_TIMEOUT;
          end
        end
        S_WAIT: begin
          r_cnt <= w_cnt_next;
          if (i_mem_rvalid) begin
            r_resp_data <= r_op[OP_STORE] ? '0 : w_rdata_ext;
            r_resp_err  <= ERR_OK;
          end else if (w_timeout) begin
            r_resp_data <= '0;
            r_resp_err  <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22050039_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_22050039_lsu
//  Purpose  : Directed self-checking bench for ysyx_22050039_lsu with a
//             response scoreboard (expected results queued at issue time).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_22050039_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid, o_req_ready;
  logic [3:0]  i_req_op;
  logic [63:0] i_req_base, i_req_offset, i_req_wdata;
  logic        o_resp_valid, i_resp_ready;
  logic [63:0] o_resp_data;
  logic [1:0]  o_resp_err;
  logic        o_mem_req_valid, i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        o_mem_wen;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_rvalid;
  logic [63:0] i_mem_rdata;

  int n_err = 0;
  int n_chk = 0;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  err;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ysyx_22050039_lsu #(
    .XLEN    (64),
    .TIMEOUT (8),
    .CNT_W   (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (i_req_valid),
    .o_req_ready     (o_req_ready),
    .i_req_op        (i_req_op),
    .i_req_base      (i_req_base),
    .i_req_offset    (i_req_offset),
    .i_req_wdata     (i_req_wdata),
    .o_resp_valid    (o_resp_valid),
    .i_resp_ready    (i_resp_ready),
    .o_resp_data     (o_resp_data),
    .o_resp_err      (o_resp_err),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wen       (o_mem_wen),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wmask     (o_mem_wmask),
    .i_mem_rvalid    (i_mem_rvalid),
    .i_mem_rdata     (i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one op for a single cycle and queue its expected response
  task automatic issue(input logic [3:0] op, input logic [63:0] base, input logic [63:0] off,
                       input logic [63:0] wdata, input logic [63:0] edata, input logic [1:0] eerr);
    chk("req_ready_before_issue", {63'd0, o_req_ready}, 64'd1);
    i_req_valid  = 1'b1;
    i_req_op     = op;
    i_req_base   = base;
    i_req_offset = off;
    i_req_wdata  = wdata;
    sb_q.push_back(exp_t'({edata, eerr}));
    @(negedge clk);
    i_req_valid  = 1'b0;
    i_req_wdata  = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  // Check the memory request, handshake it, then return rdata one cycle later.
  // With early set, a bogus rvalid accompanies the handshake and must be ignored.
  task automatic mem_serve(input logic [63:0] eaddr, input logic ewen, input logic [7:0] emask,
                           input logic [63:0] ewdata, input logic [63:0] rdata, input bit early);
    int i = 0;
    while (!o_mem_req_valid && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk("mem_req_valid", {63'd0, o_mem_req_valid}, 64'd1);
    if (!o_mem_req_valid) return;
    chk("mem_addr", o_mem_addr, eaddr);
    chk("mem_wen", {63'd0, o_mem_wen}, {63'd0, ewen});
    chk("mem_wmask", {56'd0, o_mem_wmask}, {56'd0, emask});
    chk("mem_wdata", o_mem_wdata, ewdata);
    i_mem_req_ready = 1'b1;
    if (early) begin
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = ~rdata;
    end
    @(negedge clk);
    i_mem_req_ready = 1'b0;
    chk("mem_req_drop", {63'd0, o_mem_req_valid}, 64'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = rdata;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
  endtask

  // Wait for a response, compare with the scoreboard head, keep resp_ready low
  // for 'hold' cycles while checking stability, then consume it.
  task automatic wait_resp(input int hold);
    int   i = 0;
    exp_t e;
    while (!o_resp_valid && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk("resp_valid", {63'd0, o_resp_valid}, 64'd1);
    if (!o_resp_valid) return;
    chk("sb_not_empty", {63'd0, sb_q.size() != 0}, 64'd1);
    if (sb_q.size() == 0) return;
    e = sb_q.pop_front();
    chk("resp_data", o_resp_data, e.data);
    chk("resp_err", {62'd0, o_resp_err}, {62'd0, e.err});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", {63'd0, o_resp_valid}, 64'd1);
      chk("hold_data", o_resp_data, e.data);
      chk("hold_err", {62'd0, o_resp_err}, {62'd0, e.err});
    end
    i_resp_ready = 1'b1;
    @(negedge clk);
    i_resp_ready = 1'b0;
    chk("resp_drop", {63'd0, o_resp_valid}, 64'd0);
    chk("ready_after_resp", {63'd0, o_req_ready}, 64'd1);
  endtask

  initial begin
    int cyc;
    int req_seen;
    i_req_valid = 1'b0; i_req_op = 4'd0; i_req_base = '0; i_req_offset = '0; i_req_wdata = '0;
    i_resp_ready = 1'b0; i_mem_req_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", {63'd0, o_resp_valid}, 64'd0);
    chk("rst_resp_data", o_resp_data, 64'd0);
    chk("rst_resp_err", {62'd0, o_resp_err}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, o_mem_req_valid}, 64'd0);
    chk("rst_mem_wen", {63'd0, o_mem_wen}, 64'd0);
    chk("rst_mem_addr", o_mem_addr, 64'd0);
    chk("rst_mem_wdata", o_mem_wdata, 64'd0);
    chk("rst_mem_wmask", {56'd0, o_mem_wmask}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {63'd0, o_req_ready}, 64'd1);

    // Lw, upper word, negative value sign-extended
    issue(4'b0010, 64'h8000_0000, 64'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 2'b00);
    mem_serve(64'h8000_0000, 1'b0, 8'hF0, 64'd0, 64'hFFFF_FFFE_0000_0000, 1'b0);
    wait_resp(0);

    // Sb onto byte lane 3
    issue(4'b1000, 64'h8000_0003, 64'd0, 64'h0000_0000_0000_00AB, 64'd0, 2'b00);
    mem_serve(64'h8000_0000, 1'b1, 8'h08, 64'h0000_0000_AB00_0000, 64'h1111_2222_3333_4444, 1'b0);
    wait_resp(0);

    // Misaligned Lh: response right after accept, no memory traffic
    issue(4'b0001, 64'h8000_0001, 64'd0, 64'd0, 64'd0, 2'b01);
    chk("mis_resp_valid", {63'd0, o_resp_valid}, 64'd1);
    chk("mis_no_mem", {63'd0, o_mem_req_valid}, 64'd0);
    wait_resp(0);

    // Lbu / Lb of top byte
    issue(4'b0100, 64'h8000_0007, 64'd0, 64'd0, 64'h0000_0000_0000_0080, 2'b00);
    mem_serve(64'h8000_0000, 1'b0, 8'h80, 64'd0, 64'h8011_2233_4455_6677, 1'b0);
    wait_resp(0);
    issue(4'b0000, 64'h8000_0007, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 2'b00);
    mem_serve(64'h8000_0000, 1'b0, 8'h80, 64'd0, 64'h8011_2233_4455_6677, 1'b0);
    wait_resp(0);

    // Lwu via negative offset; bogus rvalid in the handshake cycle
    issue(4'b0110, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'h0000_0000_F000_0001, 2'b00);
    mem_serve(64'h8000_0008, 1'b0, 8'h0F, 64'd0, 64'h7777_7777_F000_0001, 1'b1);
    wait_resp(0);

    // Sd full word, then misaligned Ld
    issue(4'b1011, 64'h8000_0200, 64'd0, 64'h0123_4567_89AB_CDEF, 64'd0, 2'b00);
    mem_serve(64'h8000_0200, 1'b1, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'd0, 1'b0);
    wait_resp(0);
    issue(4'b0011, 64'h8000_0004, 64'd0, 64'd0, 64'd0, 2'b01);
    wait_resp(0);

    // Timeout: request accepted, read data never returns
    i_mem_req_ready = 1'b1;
    issue(4'b0010, 64'h8000_0010, 64'd0, 64'd0, 64'd0, 2'b10);
    cyc = 0;
    req_seen = 0;
    while (!o_resp_valid && cyc < 30) begin
      if (o_mem_req_valid) req_seen++;
      cyc++;
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(cyc), 64'd8);
    chk("tmo_req_once", 64'(req_seen), 64'd1);
    chk("tmo_mem_drop", {63'd0, o_mem_req_valid}, 64'd0);
    i_mem_req_ready = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    wait_resp(1);
    @(negedge clk);
    chk("late_rvalid_idle", {63'd0, o_resp_valid}, 64'd0);
    i_mem_rvalid = 1'b0;
    issue(4'b0011, 64'h8000_0008, 64'd0, 64'd0, 64'h0123_4567_89AB_CDEF, 2'b00);
    mem_serve(64'h8000_0008, 1'b0, 8'hFF, 64'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    wait_resp(0);

    // Reset while waiting for read data aborts the op silently
    issue(4'b0011, 64'h8000_0100, 64'd8, 64'd0, 64'd0, 2'b00);
    cyc = 0;
    while (!o_mem_req_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_req_valid", {63'd0, o_mem_req_valid}, 64'd1);
    i_mem_req_ready = 1'b1;
    @(negedge clk);
    i_mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_resp_valid", {63'd0, o_resp_valid}, 64'd0);
    chk("abort_req_ready", {63'd0, o_req_ready}, 64'd1);
    chk("abort_mem_valid", {63'd0, o_mem_req_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 64'hCAFE_CAFE_CAFE_CAFE;
    @(negedge clk);
    i_mem_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("no_stale_resp", {63'd0, o_resp_valid}, 64'd0);
      @(negedge clk);
    end

    // Lhu at lane 2 with a slow consumer
    issue(4'b0101, 64'h8000_0102, 64'd0, 64'd0, 64'h0000_0000_0000_9876, 2'b00);
    mem_serve(64'h8000_0100, 1'b0, 8'h0C, 64'd0, 64'h0000_0000_9876_0000, 1'b0);
    wait_resp(3);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
